// File: rtl/ram_burst_ctrl.sv
// Burst command front-end for a 16x16 single-port synchronous RAM.
// Zero-fills the RAM after reset or on request, then serves write/read bursts.
module ram_burst_ctrl #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_req_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_wr_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [ADDR_W-1:0] cmd_len_i,
   input  logic              wdata_valid_i,
   output logic              wdata_ready_o,
   input  logic [DATA_W-1:0] wdata_i,
   output logic              rdata_valid_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              busy_o,
   output logic              ram_en_o,
   output logic              ram_wen_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_din_o,
   input  logic [DATA_W-1:0] ram_dout_i
);

   // state   | meaning
   // CLEAR   | writing zero to RAM[ptr], one word per cycle
   // IDLE    | waiting for clr_req or a burst command
   // WRITE   | one RAM write per wdata handshake
   // READ    | one RAM read issued per cycle, no backpressure
   typedef enum logic [1:0] {
      S_CLEAR = 2'd0,
      S_IDLE  = 2'd1,
      S_WRITE = 2'd2,
      S_READ  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                rdata_valid_q, rdata_valid_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= S_CLEAR;
         ptr_q         <= '0;
         cnt_q         <= '0;
         rdata_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         cnt_q         <= cnt_d;
         rdata_valid_q <= rdata_valid_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      cnt_d         = cnt_q;
      // RAM output is valid the cycle after every read issue
      rdata_valid_d = (state_q == S_READ);
      case (state_q)
         S_CLEAR: begin
            ptr_d = ptr_q + ADDR_W'(1);
            if (ptr_q == ADDR_W'(DEPTH - 1)) begin
               state_d = S_IDLE;
               ptr_d   = '0;
            end
         end
         S_IDLE: begin
            if (clr_req_i) begin
               state_d = S_CLEAR;
               ptr_d   = '0;
            end else if (cmd_valid_i) begin
               ptr_d   = cmd_addr_i;
               cnt_d   = cmd_len_i;
               state_d = cmd_wr_i ? S_WRITE : S_READ;
            end
         end
         S_WRITE: begin
            if (wdata_valid_i) begin
               ptr_d = ptr_q + ADDR_W'(1);
               cnt_d = cnt_q - ADDR_W'(1);
               if (cnt_q == '0) state_d = S_IDLE;
            end
         end
         S_READ: begin
            ptr_d = ptr_q + ADDR_W'(1);
            cnt_d = cnt_q - ADDR_W'(1);
            if (cnt_q == '0) state_d = S_IDLE;
         end
         default: state_d = S_CLEAR;
      endcase
   end

   always_comb begin
      cmd_ready_o   = 1'b0;
      wdata_ready_o = 1'b0;
      busy_o        = 1'b1;
      ram_en_o      = 1'b0;
      ram_wen_o     = 1'b0;
      ram_addr_o    = ptr_q;
      ram_din_o     = '0;
      case (state_q)
         S_CLEAR: begin
            ram_en_o  = 1'b1;
            ram_wen_o = 1'b1;
         end
         S_IDLE: begin
            busy_o      = 1'b0;
            cmd_ready_o = ~clr_req_i;
         end
         S_WRITE: begin
            wdata_ready_o = 1'b1;
            ram_en_o      = wdata_valid_i;
            ram_wen_o     = wdata_valid_i;
            ram_din_o     = wdata_i;
         end
         S_READ: begin
            ram_en_o = 1'b1;
         end
         default: ;
      endcase
   end

   assign rdata_valid_o = rdata_valid_q;
   assign rdata_o       = ram_dout_i;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl: behavioural RAM on the DUT pins, reference memory
// image, and a scoreboard fed by burst stimulus and drained by a read monitor.
module tb_ram_burst_ctrl;
   localparam int DW = 16;
   localparam int AW = 4;
   localparam int D  = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clr_req = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_wr = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [AW-1:0] cmd_len = '0;
   logic          wdata_valid = 1'b0;
   logic          wdata_ready;
   logic [DW-1:0] wdata = '0;
   logic          rdata_valid;
   logic [DW-1:0] rdata;
   logic          busy;
   logic          ram_en, ram_wen;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] ram     [D];
   logic [DW-1:0] ref_mem [D];
   logic [DW-1:0] wbuf    [D];
   int            gbuf    [D];
   logic [DW-1:0] exp_q [$];
   logic [AW-1:0] addr_q[$];

   always #5 clk = ~clk;

   ram_burst_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
      .clk_i(clk), .rst_i(rst), .clr_req_i(clr_req),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_wr_i(cmd_wr),
      .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
      .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready), .wdata_i(wdata),
      .rdata_valid_o(rdata_valid), .rdata_o(rdata), .busy_o(busy),
      .ram_en_o(ram_en), .ram_wen_o(ram_wen), .ram_addr_o(ram_addr),
      .ram_din_o(ram_din), .ram_dout_i(ram_dout)
   );

   // external single-port RAM, deliberately filled with garbage at time 0
   initial begin
      for (int i = 0; i < D; i++) ram[i] = DW'($urandom);
      ram_dout = DW'($urandom);
   end

   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_wen) ram[ram_addr] <= ram_din;
         else         ram_dout      <= ram[ram_addr];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: every returned word and every issued read address is scored
   always @(negedge clk) begin
      if (!rst) begin
         if (rdata_valid) begin
            if (exp_q.size() == 0) chk("rdata_unexpected", 32'd1, 32'd0);
            else                   chk("rdata", rdata, exp_q.pop_front());
         end
         if (ram_en && !ram_wen) begin
            if (addr_q.size() == 0) chk("rd_addr_unexpected", 32'd1, 32'd0);
            else                    chk("rd_addr", ram_addr, addr_q.pop_front());
         end
      end
   end

   task automatic clear_ref();
      for (int i = 0; i < D; i++) ref_mem[i] = '0;
   endtask

   // entered at posedge+1 with the DUT in the first CLEAR cycle
   task automatic check_clear_sweep();
      for (int i = 0; i < D; i++) begin
         @(negedge clk);
         chk("clr_en", ram_en, 1);
         chk("clr_wen", ram_wen, 1);
         chk("clr_din", ram_din, 0);
         chk("clr_addr", ram_addr, i);
         chk("clr_busy", busy, 1);
         chk("clr_cmd_ready", cmd_ready, 0);
         chk("clr_wdata_ready", wdata_ready, 0);
         chk("clr_rdata_valid", rdata_valid, 0);
      end
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_cmd_ready", cmd_ready, 1);
      chk("idle_ram_en", ram_en, 0);
      clear_ref();
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; cmd_valid = 1'b0; wdata_valid = 1'b0; clr_req = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_rdata_valid", rdata_valid, 0);
      chk("rst_busy", busy, 1);
      chk("rst_ram_en", ram_en, 1);
      chk("rst_ram_wen", ram_wen, 1);
      chk("rst_ram_din", ram_din, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_wdata_ready", wdata_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      addr_q.delete();
      check_clear_sweep();
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (!busy) done = 1;
      end
      chk("idle_timeout", done, 1);
   endtask

   // returns at posedge+1 just after the accepting edge
   task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [AW-1:0] l);
      bit ok = 0;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_len = l;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (cmd_ready) ok = 1;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      chk("cmd_accept", ok, 1);
   endtask

   // sends the first n words of wbuf; gbuf[w] idle cycles precede word w
   task automatic write_burst(input logic [AW-1:0] a, input logic [AW-1:0] l, input int n);
      logic [AW-1:0] idx;
      issue(1'b1, a, l);
      for (int w = 0; w < n; w++) begin
         for (int g = 0; g < gbuf[w]; g++) begin
            wdata_valid = 1'b0;
            @(negedge clk);
            chk("gap_wdata_ready", wdata_ready, 1);
            chk("gap_ram_en", ram_en, 0);
            @(posedge clk); #1;
         end
         idx = a + AW'(w);
         wdata_valid = 1'b1;
         wdata = wbuf[w];
         @(negedge clk);
         chk("wr_wdata_ready", wdata_ready, 1);
         chk("wr_ram_en", ram_en, 1);
         chk("wr_ram_wen", ram_wen, 1);
         chk("wr_addr", ram_addr, idx);
         chk("wr_din", ram_din, wbuf[w]);
         ref_mem[idx] = wbuf[w];
         @(posedge clk); #1;
      end
      wdata_valid = 1'b0;
      if (n == int'(l) + 1) begin
         @(negedge clk);
         chk("wr_done_idle", busy, 0);
      end
   endtask

   task automatic read_burst(input logic [AW-1:0] a, input logic [AW-1:0] l);
      logic [AW-1:0] idx;
      for (int i = 0; i <= int'(l); i++) begin
         idx = a + AW'(i);
         exp_q.push_back(ref_mem[idx]);
         addr_q.push_back(idx);
      end
      issue(1'b0, a, l);
      for (int k = 0; k <= int'(l) + 1; k++) begin
         @(negedge clk);
         chk("rd_valid_timing", rdata_valid, (k >= 1) ? 1 : 0);
         chk("rd_busy", busy, (k <= int'(l)) ? 1 : 0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW-1:0] a, l;
      int r;

      // reset and post-reset zero fill
      do_reset();
      read_burst(4'd0, 4'd15);

      // write with a 2-cycle valid gap after the second word, then read back
      wbuf[0] = 16'hA1A1; wbuf[1] = 16'hA2A2; wbuf[2] = 16'hA3A3; wbuf[3] = 16'hA4A4;
      gbuf[0] = 0; gbuf[1] = 0; gbuf[2] = 2; gbuf[3] = 0;
      write_burst(4'd3, 4'd3, 4);
      read_burst(4'd3, 4'd3);

      // address wrap
      wbuf[0] = 16'h0011; wbuf[1] = 16'h0022; wbuf[2] = 16'h0033; wbuf[3] = 16'h0044;
      for (int i = 0; i < 4; i++) gbuf[i] = 0;
      write_burst(4'd14, 4'd3, 4);
      read_burst(4'd14, 4'd3);

      // single-word bursts at the top address
      wbuf[0] = 16'hBEEF; gbuf[0] = 1;
      write_burst(4'd15, 4'd0, 1);
      read_burst(4'd15, 4'd0);

      // clr_req wins over a simultaneous command
      wait_idle();
      @(posedge clk); #1;
      clr_req = 1'b1; cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'd3; cmd_len = 4'd0;
      @(negedge clk);
      chk("clr_vs_cmd_ready", cmd_ready, 0);
      @(posedge clk); #1;
      clr_req = 1'b0; cmd_valid = 1'b0;
      check_clear_sweep();
      read_burst(4'd0, 4'd15);

      // reset in the middle of a write burst
      for (int i = 0; i < 4; i++) begin wbuf[i] = DW'($urandom); gbuf[i] = 0; end
      write_burst(4'd8, 4'd3, 2);
      do_reset();
      read_burst(4'd0, 4'd15);

      // randomized traffic
      for (int t = 0; t < 40; t++) begin
         r = $urandom_range(0, 9);
         a = AW'($urandom);
         l = AW'($urandom);
         if (r < 4) begin
            for (int i = 0; i < D; i++) begin
               wbuf[i] = DW'($urandom);
               gbuf[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            end
            write_burst(a, l, int'(l) + 1);
         end else if (r < 9) begin
            read_burst(a, l);
         end else begin
            wait_idle();
            @(posedge clk); #1;
            clr_req = 1'b1;
            @(posedge clk); #1;
            clr_req = 1'b0;
            check_clear_sweep();
         end
      end
      read_burst(4'd0, 4'd15);

      @(negedge clk);
      chk("exp_q_drained", exp_q.size(), 0);
      chk("addr_q_drained", addr_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
